// File: rtl/i2s_audio_receiver.sv
// Left-justified 2x16-bit serial audio receiver with valid/ack handshake and overrun/frame error flags.
// Optional peak-magnitude tracker enabled by defining I2S_RX_PEAK_EN.
module i2s_audio_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        audio_bck,
  input  logic        audio_ws,
  input  logic        audio_data,
  output logic [15:0] audio_out_left,
  output logic [15:0] audio_out_right,
  output logic        sample_valid,
  input  logic        sample_ack,
  output logic        overrun,
  output logic        frame_err
`ifdef I2S_RX_PEAK_EN
  ,
  output logic [15:0] peak_level,
  input  logic        peak_clr
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_bck_sync;
  logic [2:0]  r_ws_sync;
  logic [2:0]  r_data_sync;
  logic [4:0]  r_cnt;
  logic [31:0] r_shift;
  logic        r_load;
  logic [15:0] r_left;
  logic [15:0] r_right;
  logic        r_valid;
  logic        r_overrun;
  logic        r_frame_err;
  logic        w_bck_rise;
  logic        w_ws_rise;
  logic        w_bit;
  logic        w_shift;
  logic        w_cnt_clr;
  logic        w_err;
  logic        w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bck_sync  <= '0;
      r_ws_sync   <= '0;
      r_data_sync <= '0;
    end else begin
      r_bck_sync  <= {r_bck_sync[1:0], audio_bck};
      r_ws_sync   <= {r_ws_sync[1:0], audio_ws};
      r_data_sync <= {r_data_sync[1:0], audio_data};
    end
  end

  assign w_bck_rise = r_bck_sync[1] & ~r_bck_sync[2];
  assign w_ws_rise  = r_ws_sync[1] & ~r_ws_sync[2];
  // Third stage holds data as it stood just before the bck edge was seen.
  assign w_bit      = r_data_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A ws_rise always restarts the frame first; a coincident bck_rise becomes bit 0.
  always_comb begin
    w_next    = r_state;
    w_shift   = 1'b0;
    w_cnt_clr = 1'b0;
    w_err     = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ws_rise) begin
          w_next    = SHIFT;
          w_cnt_clr = 1'b1;
          w_shift   = w_bck_rise;
        end
      end
      SHIFT: begin
        w_shift = w_bck_rise;
        if (w_ws_rise) begin
          w_cnt_clr = 1'b1;
          w_err     = (r_cnt != '0);
        end else if (w_bck_rise && (r_cnt == 5'd31)) begin
          w_next = HOLD;
          w_done = 1'b1;
        end
      end
      HOLD: begin
        if (w_ws_rise) begin
          w_next    = SHIFT;
          w_cnt_clr = 1'b1;
          w_shift   = w_bck_rise;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_load      <= w_done;
      r_frame_err <= w_err;
      if (w_shift) r_shift <= {r_shift[30:0], w_bit};
      if (w_cnt_clr)    r_cnt <= w_shift ? 5'd1 : 5'd0;
      else if (w_shift) r_cnt <= r_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_load) begin
      r_left  <= r_shift[31:16];
      r_right <= r_shift[15:0];
      r_valid <= 1'b1;
      if (r_valid && !sample_ack) r_overrun <= 1'b1;
    end else if (sample_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign audio_out_left  = r_left;
  assign audio_out_right = r_right;
  assign sample_valid    = r_valid;
  assign overrun         = r_overrun;
  assign frame_err       = r_frame_err;

`ifdef I2S_RX_PEAK_EN
  function automatic logic [15:0] f_mag(input logic [15:0] s);
    if (s == 16'h8000) return 16'h7FFF;
    return s[15] ? (~s + 16'd1) : s;
  endfunction

  logic [15:0] w_mag_l;
  logic [15:0] w_mag_r;
  logic [15:0] w_pair_mag;
  logic [15:0] r_peak;

  assign w_mag_l    = f_mag(r_shift[31:16]);
  assign w_mag_r    = f_mag(r_shift[15:0]);
  assign w_pair_mag = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (r_load) begin
      if (peak_clr || (w_pair_mag > r_peak)) r_peak <= w_pair_mag;
    end else if (peak_clr) begin
      r_peak <= '0;
    end
  end

  assign peak_level = r_peak;
`endif

endmodule

// File: doc/i2s_audio_receiver.md
I2S_AUDIO_RECEIVER -- requirements
Module: i2s_audio_receiver

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port audio_bck, input, 1 bit: external serial bit clock, asynchronous to clk, frequency at most clk/4.
REQ-004 SHALL have port audio_ws, input, 1 bit: word select; a rising edge marks frame start.
REQ-005 SHALL have port audio_data, input, 1 bit: serial data, MSB first.
REQ-006 SHALL have port audio_out_left, output, 16 bits: last complete left sample.
REQ-007 SHALL have port audio_out_right, output, 16 bits: last complete right sample.
REQ-008 SHALL have port sample_valid, output, 1 bit: new sample pair held, awaiting ack.
REQ-009 SHALL have port sample_ack, input, 1 bit: consumer acknowledge, single-cycle pulse.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, pair overwritten unacknowledged.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse, short frame discarded.
REQ-012 SHALL have port peak_level, output, 16 bits: only with I2S_RX_PEAK_EN.
REQ-013 SHALL have port peak_clr, input, 1 bit: only with I2S_RX_PEAK_EN.

Function
REQ-014 SHALL pass audio_bck, audio_ws and audio_data each through a 2-flop synchronizer plus one edge-detect flop.
REQ-015 SHALL detect bck_rise when sync stage 2 = 1 and stage 3 = 0; ws_rise is detected the same way.
REQ-016 SHALL implement FSM states IDLE, SHIFT and HOLD.
REQ-017 In IDLE after reset, the FSM SHALL ignore all bits and move to SHIFT on the first ws_rise.
REQ-018 In SHIFT, on each bck_rise the FSM SHALL shift synchronized data into a 32-bit register LSB-in, and the 5-bit bit counter SHALL increment.
REQ-019 Frame format SHALL be left-justified with no one-bit delay: bits 31..16 are left and bits 15..0 are right, MSB first.
REQ-020 The first captured bit SHALL be the first bck_rise at or after the ws_rise cycle.
REQ-021 On the 32nd bck_rise, the FSM SHALL enter HOLD, and on the next clk edge SHALL load audio_out_left/right and set sample_valid.
REQ-022 Pin-to-sample_valid latency SHALL be 4 clk edges after the 32nd audio_bck rising edge.
REQ-023 In HOLD, the FSM SHALL ignore bck_rise and return to SHIFT on the next ws_rise, with the counter cleared.
REQ-024 A ws_rise in SHIFT with counter ≠ 0 SHALL discard the partial word, pulse frame_err for one cycle, clear the counter and stay in SHIFT.
REQ-025 A ws_rise coincident with a bck_rise SHALL be handled as frame restart first, then capture of that bit as bit 0.
REQ-026 sample_ack SHALL clear sample_valid on the next edge; ack while sample_valid = 0 SHALL be ignored.
REQ-027 If a new pair completes while sample_valid = 1 with no ack in the same cycle, outputs SHALL be overwritten, sample_valid SHALL stay 1 and overrun SHALL be set.
REQ-028 If ack coincides with a completion, new data SHALL load, sample_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 While rst_n = 0, the FSM SHALL be IDLE, and the counter, shift register and synchronizers SHALL be 0.
REQ-031 While rst_n = 0, audio_out_left/right = 16'h0000, sample_valid = 0, overrun = 0, frame_err = 0, and peak_level = 16'h0000.
REQ-032 Reset mid-frame SHALL abandon the partial word; after release, no sample SHALL be produced before a fresh ws_rise.

Configuration
REQ-033 With macro I2S_RX_PEAK_EN defined, the block SHALL track peak_level = max over completed pairs of |left| and |right|, treating samples as two's complement.
REQ-034 Under I2S_RX_PEAK_EN, |16'h8000| SHALL saturate to 16'h7FFF.
REQ-035 Under I2S_RX_PEAK_EN, peak_level SHALL update on the same edge as the outputs.
REQ-036 Under I2S_RX_PEAK_EN, peak_clr SHALL zero peak_level; a clear coincident with an update SHALL load the new pair's magnitude.
REQ-037 Without I2S_RX_PEAK_EN, the ports peak_level and peak_clr and all peak logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then ws_rise, then 32 bits of 32'hA5C3_0F0F -> left = 16'hA5C3, right = 16'h0F0F, sample_valid = 1 four clk after the 32nd bck rise.
REQ-039 Two frames with no ack -> second pair on outputs, overrun = 1; a subsequent ack -> sample_valid = 0, overrun stays 1.
REQ-040 ws_rise after 20 bits, then a full frame 32'h1234_8765 -> frame_err pulses once, outputs 16'h1234/16'h8765, no overrun.
REQ-041 rst_n low after 10 bits, release, 22 more bck rises without ws -> no sample_valid; next full frame is captured correctly.
REQ-042 Ack coincident with a completion -> sample_valid stays 1, overrun = 0.
REQ-043 With I2S_RX_PEAK_EN, frames 16'h8000/16'h0001 then 16'h0100/16'hFF00 -> peak_level = 16'h7FFF; after peak_clr then frame 16'h0003/16'hFFFE -> peak_level = 16'h0003.
